// File: rtl/matrix_operand_bank.sv
// Operand/result store wrapped around the sequential matrix multiplier.
// It loads A and B from a stream, starts the multiplier, captures Z writes and streams Z out row-major.
module matrix_operand_bank #(
    parameter int M       = 4,
    parameter int M_LEN   = $clog2(M),
    parameter int CNT_LEN = $clog2(2*M*M)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              mul_start,
    input  logic              mul_done,
    input  logic [M_LEN-1:0]  a_i,
    input  logic [M_LEN-1:0]  a_j,
    input  logic [M_LEN-1:0]  b_i,
    input  logic [M_LEN-1:0]  b_j,
    output logic [31:0]       a_in,
    output logic [31:0]       b_in,
    input  logic [M_LEN-1:0]  z_i,
    input  logic [M_LEN-1:0]  z_j,
    output logic [31:0]       current_element,
    input  logic [31:0]       z_out,
    input  logic              z_stb,
    output logic              z_ack,
    output logic              out_valid,
    output logic [31:0]       out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);
    localparam int MM = M*M;
    localparam int AW = (MM > 1) ? $clog2(MM) : 1;

    typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_DUMP} state_t;

    state_t               state;
    logic [CNT_LEN-1:0]   cnt;
    logic                 z_seen;
    logic [31:0]          a_mem [MM];
    logic [31:0]          b_mem [MM];
    logic [31:0]          z_mem [MM];

    logic                 is_b;
    logic [AW-1:0]        ld_idx;
    logic [AW-1:0]        a_idx, b_idx, z_idx, d_idx;

    assign is_b   = cnt >= CNT_LEN'(MM);
    assign ld_idx = is_b ? AW'(cnt - CNT_LEN'(MM)) : AW'(cnt);
    assign a_idx  = AW'(a_i * M + a_j);
    assign b_idx  = AW'(b_i * M + b_j);
    assign z_idx  = AW'(z_i * M + z_j);
    assign d_idx  = AW'(cnt);

    assign load_ready      = (state == S_LOAD);
    assign mul_start       = (state == S_START);
    assign busy            = (state != S_LOAD);
    assign out_valid       = (state == S_DUMP);
    assign out_last        = out_valid && (cnt == CNT_LEN'(MM-1));
    assign out_data        = z_mem[d_idx];
    assign a_in            = a_mem[a_idx];
    assign b_in            = b_mem[b_idx];
    assign current_element = z_mem[z_idx];

    // Operand storage carries no reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && load_valid) begin
            if (is_b) b_mem[ld_idx] <= load_data;
            else      a_mem[ld_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_LOAD;
            cnt    <= '0;
            z_ack  <= 1'b0;
            z_seen <= 1'b0;
            for (int i = 0; i < MM; i++) z_mem[i] <= '0;
        end else begin
            z_ack  <= 1'b0;
            z_seen <= 1'b0;
            case (state)
                S_LOAD: if (load_valid) begin
                    if (!is_b) z_mem[ld_idx] <= '0;
                    if (cnt == CNT_LEN'(2*MM-1)) begin
                        cnt   <= '0;
                        state <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    // z_seen stays high while z_stb is held, so one assertion yields one capture.
                    z_seen <= z_stb;
                    if (z_stb && !z_seen) begin
                        z_mem[z_idx] <= z_out;
                        z_ack        <= 1'b1;
                    end
                    if (mul_done) begin
                        cnt   <= '0;
                        state <= S_DUMP;
                    end
                end
                S_DUMP: if (out_ready) begin
                    if (cnt == CNT_LEN'(MM-1)) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_operand_bank.sv
// Directed bench for matrix_operand_bank: load, index reads, Z handshake, dump and reset.
module tb_matrix_operand_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready, mul_start, mul_done = 1'b0;
    logic [1:0]  a_i = '0, a_j = '0, b_i = '0, b_j = '0, z_i = '0, z_j = '0;
    logic [31:0] a_in, b_in, current_element, z_out = '0, out_data;
    logic        z_stb = 1'b0, z_ack, out_valid, out_last, out_ready = 1'b0, busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] ld   [32];
    logic [31:0] zexp [16];

    typedef struct {
        logic [1:0]  ai, aj, bi, bj;
        logic [31:0] ea, eb;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    matrix_operand_bank #(.M(4)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .mul_start(mul_start), .mul_done(mul_done),
        .a_i(a_i), .a_j(a_j), .b_i(b_i), .b_j(b_j), .a_in(a_in), .b_in(b_in),
        .z_i(z_i), .z_j(z_j), .current_element(current_element),
        .z_out(z_out), .z_stb(z_stb), .z_ack(z_ack),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Streams ld[] into the bank; gap toggles load_valid, done_cyc pulses mul_done mid-load.
    task automatic do_load(input bit gap, input int done_cyc);
        int  k = 0;
        int  cyc = 0;
        bit  ph = 1'b0;
        while (k < 32 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            ph = !ph;
            load_valid = gap ? ph : 1'b1;
            load_data  = ld[k];
            mul_done   = (cyc == done_cyc);
            if (load_valid && load_ready) k++;
        end
        chk("load_words_accepted", 32'(k), 32'd32);
        @(negedge clk);
        load_valid = 1'b0;
        mul_done   = 1'b0;
        chk("mul_start_pulse", 32'(mul_start), 32'd1);
        chk("load_ready_after_last", 32'(load_ready), 32'd0);
        @(negedge clk);
        chk("mul_start_one_cycle", 32'(mul_start), 32'd0);
        chk("load_ready_in_run", 32'(load_ready), 32'd0);
        chk("busy_in_run", 32'(busy), 32'd1);
    endtask

    task automatic z_write(input logic [1:0] i, input logic [1:0] j, input logic [31:0] v);
        @(negedge clk);
        z_i = i; z_j = j; z_out = v; z_stb = 1'b1;
        @(negedge clk);
        z_stb = 1'b0;
        chk("z_ack_single", 32'(z_ack), 32'd1);
        @(negedge clk);
        chk("z_ack_drop", 32'(z_ack), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_z_ack", 32'(z_ack), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_z_zero", current_element, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // z_stb outside S_RUN is ignored
        z_i = 2'd1; z_j = 2'd1; z_out = 32'hDEADBEEF; z_stb = 1'b1;
        @(negedge clk);
        z_stb = 1'b0;
        chk("z_ack_in_load", 32'(z_ack), 32'd0);
        @(negedge clk);
        chk("z_unchanged_in_load", current_element, 32'h0);

        // Load 1: A = I4, B = 2.0 everywhere, load_valid toggling, stray mul_done
        for (int k = 0; k < 16; k++) ld[k] = (k % 5 == 0) ? 32'h3F800000 : 32'h0;
        for (int k = 16; k < 32; k++) ld[k] = 32'h40000000;
        do_load(1'b1, 5);

        vecs[0] = '{2'd2, 2'd2, 2'd1, 2'd3, 32'h3F800000, 32'h40000000};
        vecs[1] = '{2'd0, 2'd1, 2'd0, 2'd0, 32'h00000000, 32'h40000000};
        vecs[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 32'h3F800000, 32'h40000000};
        vecs[3] = '{2'd1, 2'd0, 2'd2, 2'd1, 32'h00000000, 32'h40000000};
        for (int v = 0; v < 4; v++) begin
            a_i = vecs[v].ai; a_j = vecs[v].aj; b_i = vecs[v].bi; b_j = vecs[v].bj;
            #1;
            chk($sformatf("a_in_v%0d", v), a_in, vecs[v].ea);
            chk($sformatf("b_in_v%0d", v), b_in, vecs[v].eb);
        end

        // z_stb held 4 cycles -> a single ack and write
        for (int k = 0; k < 16; k++) zexp[k] = 32'h0;
        @(negedge clk);
        z_i = 2'd1; z_j = 2'd2; z_out = 32'h41200000; z_stb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("z_ack_hold_c%0d", c), 32'(z_ack), (c == 0) ? 32'd1 : 32'd0);
        end
        z_stb = 1'b0;
        zexp[6] = 32'h41200000;
        chk("z_readback_1_2", current_element, 32'h41200000);
        @(negedge clk);
        @(negedge clk);
        z_write(2'd3, 2'd0, 32'h12345678);
        zexp[12] = 32'h12345678;

        // mul_done with a pending z_stb: write then dump
        @(negedge clk);
        mul_done = 1'b1; z_stb = 1'b1;
        z_i = 2'd0; z_j = 2'd3; z_out = 32'hCAFEF00D;
        zexp[3] = 32'hCAFEF00D;
        @(negedge clk);
        mul_done = 1'b0; z_stb = 1'b0;
        chk("z_ack_with_done", 32'(z_ack), 32'd1);
        chk("out_valid_dump", 32'(out_valid), 32'd1);

        begin
            int n = 0;
            int cyc = 0;
            bit ph = 1'b1;
            while (n < 16 && cyc < 100) begin
                @(negedge clk);
                cyc++;
                out_ready = ph;
                ph = !ph;
                chk($sformatf("dump_valid_%0d", n), 32'(out_valid), 32'd1);
                chk($sformatf("dump_data_%0d", n), out_data, zexp[n]);
                chk($sformatf("dump_last_%0d", n), 32'(out_last), (n == 15) ? 32'd1 : 32'd0);
                if (out_ready && out_valid) n++;
            end
            chk("dump_word_count", 32'(n), 32'd16);
        end
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_dump_load_ready", 32'(load_ready), 32'd1);
        chk("post_dump_busy", 32'(busy), 32'd0);
        chk("post_dump_out_valid", 32'(out_valid), 32'd0);

        // Reset after 10 words of a partial load
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            load_valid = 1'b1; load_data = 32'hFFFF0000 + 32'(k);
        end
        @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midload_rst_load_ready", 32'(load_ready), 32'd1);
        chk("midload_rst_busy", 32'(busy), 32'd0);
        z_i = 2'd1; z_j = 2'd2; #1;
        chk("rst_clears_z_1_2", current_element, 32'h0);
        z_i = 2'd3; z_j = 2'd0; #1;
        chk("rst_clears_z_3_0", current_element, 32'h0);
        z_i = 2'd0; z_j = 2'd3; #1;
        chk("rst_clears_z_0_3", current_element, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load 2: distinct words to exercise index mapping
        for (int k = 0; k < 16; k++) ld[k] = 32'(k + 1);
        for (int k = 16; k < 32; k++) ld[k] = 32'h100 + 32'(k - 16);
        do_load(1'b0, 0);
        vecs[4] = '{2'd0, 2'd0, 2'd0, 2'd0, 32'd1,  32'h100};
        vecs[5] = '{2'd1, 2'd2, 2'd3, 2'd1, 32'd7,  32'h10D};
        vecs[6] = '{2'd3, 2'd3, 2'd2, 2'd0, 32'd16, 32'h108};
        vecs[7] = '{2'd2, 2'd1, 2'd0, 2'd3, 32'd10, 32'h103};
        for (int v = 4; v < 8; v++) begin
            a_i = vecs[v].ai; a_j = vecs[v].aj; b_i = vecs[v].bi; b_j = vecs[v].bj;
            #1;
            chk($sformatf("a_in_v%0d", v), a_in, vecs[v].ea);
            chk($sformatf("b_in_v%0d", v), b_in, vecs[v].eb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
